// File: rtl/block_cla_pipe_adder.sv
// Two-stage pipelined block carry-lookahead adder/subtractor, valid/ready.
// Define BLOCK_CLA_FLAGS_EN to add registered ovf and zero outputs.
module block_cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int NBLK  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BLOCK_CLA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    logic             w_stall;
    logic             w_adv;
    logic [WIDTH-1:0] w_bm;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic             w_c0;
    logic [NBLK-1:0]  w_gg;
    logic [NBLK-1:0]  w_pg;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic             r_c0;
    logic [NBLK-1:0]  r_gg;
    logic [NBLK-1:0]  r_pg;

    logic [NBLK:0]    w_bc;
    logic [WIDTH-1:0] w_ci;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_stall  = r_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    // Subtract is a + ~b + 1, so the carry-in is forced high.
    assign w_bm = sub ? ~b : b;
    assign w_g  = a & w_bm;
    assign w_p  = a ^ w_bm;
    assign w_c0 = sub | cin;

    always_comb begin : grp_gen
        logic [3:0] w_bg;
        logic [3:0] w_bp;
        w_gg = '0;
        w_pg = '0;
        for (int j = 0; j < NBLK; j++) begin
            w_bg    = w_g[4*j +: 4];
            w_bp    = w_p[4*j +: 4];
            w_pg[j] = &w_bp;
            w_gg[j] = w_bg[3]
                    | (w_bp[3] & w_bg[2])
                    | (w_bp[3] & w_bp[2] & w_bg[1])
                    | ((&w_bp[3:1]) & w_bg[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_g        <= '0;
            r_p        <= '0;
            r_c0       <= 1'b0;
            r_gg       <= '0;
            r_pg       <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_g        <= w_g;
            r_p        <= w_p;
            r_c0       <= w_c0;
            r_gg       <= w_gg;
            r_pg       <= w_pg;
        end
    end

    // Each block carry is a flat sum of products over G*/P*, not a ripple.
    always_comb begin : blk_carry
        logic w_t;
        logic w_c;
        w_bc    = '0;
        w_bc[0] = r_c0;
        for (int j = 1; j <= NBLK; j++) begin
            w_t = r_c0;
            for (int m = 0; m < j; m++)
                w_t = w_t & r_pg[m];
            w_c = w_t;
            for (int k = 0; k < j; k++) begin
                w_t = r_gg[k];
                for (int m = k + 1; m < j; m++)
                    w_t = w_t & r_pg[m];
                w_c = w_c | w_t;
            end
            w_bc[j] = w_c;
        end
    end

    always_comb begin : bit_carry
        logic w_t;
        logic w_c;
        w_ci = '0;
        for (int j = 0; j < NBLK; j++) begin
            for (int i = 0; i < 4; i++) begin
                w_t = w_bc[j];
                for (int m = 0; m < i; m++)
                    w_t = w_t & r_p[4*j+m];
                w_c = w_t;
                for (int k = 0; k < i; k++) begin
                    w_t = r_g[4*j+k];
                    for (int m = k + 1; m < i; m++)
                        w_t = w_t & r_p[4*j+m];
                    w_c = w_c | w_t;
                end
                w_ci[4*j+i] = w_c;
            end
        end
    end

    assign w_sum  = r_p ^ w_ci;
    assign w_cout = w_bc[NBLK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_adv) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

`ifdef BLOCK_CLA_FLAGS_EN
    logic w_ovf;
    logic w_zero;
    logic r_ovf;
    logic r_zero;

    assign w_ovf  = w_ci[WIDTH-1] ^ w_cout;
    assign w_zero = ~(|w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv && r_s1_valid) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`endif

endmodule

// File: tb/tb_block_cla_pipe_adder.sv
// Scoreboard bench: three widths (4, 16, 64) driven in lockstep from one
// stimulus stream, each result compared with a plain-arithmetic model.
module tb_block_cla_pipe_adder;

    typedef struct packed {
        logic [66:0] e4;
        logic [66:0] e16;
        logic [66:0] e64;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;

    logic        in_ready4, in_ready16, in_ready64;
    logic        out_valid4, out_valid16, out_valid64;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [63:0] sum64;
    logic        cout4, cout16, cout64;
    logic        ovf4, ovf16, ovf64;
    logic        zero4, zero16, zero64;

`ifndef BLOCK_CLA_FLAGS_EN
    assign {ovf4, ovf16, ovf64}    = 3'b000;
    assign {zero4, zero16, zero64} = 3'b000;
`endif

    int          checks = 0;
    int          errors = 0;
    int          nres = 0;
    exp_t        q[$];
    logic        rand_rdy;
    logic        prev_stall;
    logic [66:0] prev16;

    always #5 clk = ~clk;

    block_cla_pipe_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4)
`ifdef BLOCK_CLA_FLAGS_EN
        , .ovf(ovf4), .zero(zero4)
`endif
    );

    block_cla_pipe_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready16),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16)
`ifdef BLOCK_CLA_FLAGS_EN
        , .ovf(ovf16), .zero(zero16)
`endif
    );

    block_cla_pipe_adder #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid64), .out_ready(out_ready),
        .sum(sum64), .cout(cout64)
`ifdef BLOCK_CLA_FLAGS_EN
        , .ovf(ovf64), .zero(zero64)
`endif
    );

    function automatic logic [66:0] pk(logic z, logic o, logic c,
                                       logic [63:0] s);
        return {z, o, c, s};
    endfunction

    // Reference: two's-complement add of masked operands in 65-bit arithmetic.
    function automatic logic [66:0] model(int w, logic [63:0] va,
                                          logic [63:0] vb, logic vc,
                                          logic vs);
        logic [63:0] m;
        logic [63:0] am;
        logic [63:0] bb;
        logic [63:0] s;
        logic [64:0] full;
        logic        co;
        logic        ov;
        logic        z;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = va & m;
        bb   = (vs ? ~vb : vb) & m;
        full = {1'b0, am} + {1'b0, bb} + (vs ? 65'd1 : {64'd0, vc});
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        z    = (s == 64'd0);
`ifdef BLOCK_CLA_FLAGS_EN
        return pk(z, ov, co, s);
`else
        return pk(1'b0, 1'b0, co, s);
`endif
    endfunction

    task automatic chk(string name, logic [66:0] act, logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_rdy)
            out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [63:0] va, input logic [63:0] vb,
                        input logic vc, input logic vs);
        logic acc;
        exp_t e;
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready16;
            if (acc) begin
                e.e4  = model(4, va, vb, vc, vs);
                e.e16 = model(16, va, vb, vc, vs);
                e.e64 = model(64, va, vb, vc, vs);
                q.push_back(e);
            end
            cyc();
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept");
        end
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            cyc();
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic [66:0] a16;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                a16 = pk(zero16, ovf16, cout16, {48'd0, sum16});
                chk("lockstep",
                    {63'd0, in_ready4, in_ready64, out_valid4, out_valid64},
                    {63'd0, in_ready16, in_ready16, out_valid16, out_valid16});
                chk1("in_ready", in_ready16, ~(out_valid16 & ~out_ready));
                if (prev_stall)
                    chk("stall_hold", {out_valid16, a16[65:0]},
                        {1'b1, prev16[65:0]});
                prev_stall = out_valid16 & ~out_ready;
                prev16     = a16;
                if (out_valid16 && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h expected none",
                                 a16);
                    end else begin
                        e = q.pop_front();
                        chk("res_w4",
                            pk(zero4, ovf4, cout4, {60'd0, sum4}), e.e4);
                        chk("res_w16", a16, e.e16);
                        chk("res_w64",
                            pk(zero64, ovf64, cout64, sum64), e.e64);
                        nres++;
                    end
                end
            end
        end
    endtask

    initial begin
        int          base;
        logic [63:0] va;
        logic [63:0] vb;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        rand_rdy   = 1'b0;
        prev_stall = 1'b0;
        prev16     = '0;
        fork
            monitor();
        join_none

        #1;
        chk("reset_state",
            pk(zero16, ovf16, cout16, {47'd0, out_valid16, sum16}), 67'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1("ready_after_reset", in_ready16, 1'b1);

        send(64'h00FF, 64'h0001, 1'b0, 1'b0);
        chk1("lat_not_early", out_valid16, 1'b0);
        cyc();
        chk("lat_two_cycles", {49'd0, out_valid16, cout16, sum16},
            {49'd0, 1'b1, 1'b0, 16'h0100});
        idle(2);

        send(64'hFFFF, 64'h0000, 1'b1, 1'b0);
        send(64'h0005, 64'h0007, 1'b1, 1'b1);
        send(64'h8000, 64'h0001, 1'b0, 1'b1);
        idle(4);

        base = nres;
        send(64'h1111, 64'h2222, 1'b0, 1'b0);
        send(64'hFFFF, 64'h0001, 1'b0, 1'b0);
        out_ready = 1'b0;
        fork
            begin
                send(64'h7FFF, 64'h0001, 1'b0, 1'b0);
                send(64'h0003, 64'h0009, 1'b0, 1'b1);
            end
            begin
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    chk1("bp_in_ready", in_ready16, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk_int("bp_count", nres - base, 4);

        base = nres;
        send(64'h1234, 64'h4321, 1'b1, 1'b0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_flush",
            pk(zero16, ovf16, cout16, {47'd0, out_valid16, sum16}), 67'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1("ready_after_reset2", in_ready16, 1'b1);
        idle(5);
        chk_int("rst_no_ghost", nres - base, 0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0)
                idle($urandom_range(1, 2));
            case ($urandom_range(0, 7))
                0: begin va = '1; vb = '0; end
                1: begin va = '0; vb = '1; end
                2: begin va = '1; vb = '1; end
                3: begin va = {1'b1, 63'd0}; vb = {$urandom(), $urandom()}; end
                default: begin
                    va = {$urandom(), $urandom()};
                    vb = {$urandom(), $urandom()};
                end
            endcase
            send(va, vb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        idle(8);
        chk_int("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
